// File: rtl/dmem_misalign_splitter_pkg.sv
// Shared types and constants for the data-memory misalignment splitter.
// Memory access types, request functions, FSM states and the beat plan.
package dmem_misalign_splitter_pkg;

    localparam logic [2:0] MT_B = 3'd1;
    localparam logic [2:0] MT_H = 3'd2;
    localparam logic [2:0] MT_W = 3'd3;

    localparam logic M_XRD = 1'b0;
    localparam logic M_XWR = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_e;

    typedef struct packed {
        logic       split;
        logic [2:0] nbeats;
    } beat_plan_t;

    // Byte lane k of a 32-bit word, returned LSB-aligned.
    function automatic logic [7:0] beat_byte(input logic [31:0] data, input logic [1:0] k);
        logic [31:0] shifted;
        shifted = data >> {k, 3'b000};
        return shifted[7:0];
    endfunction

endpackage

// File: rtl/dmem_beat_planner.sv
// Decides how many aligned beats a request needs and whether it is split
// into byte beats; purely combinational.
module dmem_beat_planner
    import dmem_misalign_splitter_pkg::*;
#(
    parameter bit SPLIT_EN = 1'b1
)
(
    input  logic [2:0] typ,
    input  logic [1:0] addr_lo,
    output beat_plan_t plan
);

    always_comb begin
        plan = '{split: 1'b0, nbeats: 3'd1};
        if (SPLIT_EN) begin
            if (typ == MT_H && addr_lo[0]) begin
                plan = '{split: 1'b1, nbeats: 3'd2};
            end else if (typ == MT_W && addr_lo != 2'b00) begin
                plan = '{split: 1'b1, nbeats: 3'd4};
            end
        end
    end

endmodule

// File: rtl/dmem_misalign_splitter.sv
// Turns misaligned half/word core requests into aligned byte beats to the
// data memory and merges the read bytes back into a single core response.
//
//   state | meaning
//   IDLE  | ready for a core request
//   ISSUE | one-cycle beat pulse to memory
//   WAIT  | waiting for the memory beat completion
//   DONE  | one-cycle core response pulse
module dmem_misalign_splitter
    import dmem_misalign_splitter_pkg::*;
#(
    parameter bit SPLIT_EN = 1'b1
)
(
    input  logic        clock,
    input  logic        reset,
    input  logic        core_req_valid,
    output logic        core_req_ready,
    input  logic [31:0] core_req_addr,
    input  logic [31:0] core_req_data,
    input  logic        core_req_fcn,
    input  logic [2:0]  core_req_typ,
    output logic        core_resp_valid,
    output logic [31:0] core_resp_data,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    output logic [31:0] mem_req_data,
    output logic        mem_req_fcn,
    output logic [2:0]  mem_req_typ,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data
);

    state_e      state_q;
    state_e      state_d;
    logic [31:0] req_addr_q;
    logic [31:0] req_data_q;
    logic        req_fcn_q;
    logic [2:0]  req_typ_q;
    logic        split_q;
    logic [1:0]  last_q;
    logic [1:0]  beat_q;
    logic [31:0] merge_q;

    beat_plan_t  plan;
    logic [2:0]  last_w;
    logic        accept;
    logic        beat_done;

    dmem_beat_planner #(
        .SPLIT_EN (SPLIT_EN)
    ) u_planner (
        .typ     (core_req_typ),
        .addr_lo (core_req_addr[1:0]),
        .plan    (plan)
    );

    assign last_w    = plan.nbeats - 3'd1;
    assign accept    = (state_q == IDLE) && core_req_valid;
    assign beat_done = (state_q == WAIT) && mem_resp_valid;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            req_addr_q <= '0;
            req_data_q <= '0;
            req_fcn_q  <= 1'b0;
            req_typ_q  <= '0;
            split_q    <= 1'b0;
            last_q     <= '0;
            beat_q     <= '0;
            merge_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                req_addr_q <= core_req_addr;
                req_data_q <= core_req_data;
                req_fcn_q  <= core_req_fcn;
                req_typ_q  <= core_req_typ;
                split_q    <= plan.split;
                last_q     <= last_w[1:0];
                beat_q     <= '0;
                merge_q    <= '0;
            end
            if (beat_done) begin
                // Merge is cleared at acceptance, so OR-ing byte lanes in is safe.
                if (req_fcn_q == M_XRD) begin
                    if (split_q) begin
                        merge_q <= merge_q | ({24'h0, mem_resp_data[7:0]} << {beat_q, 3'b000});
                    end else begin
                        merge_q <= mem_resp_data;
                    end
                end
                if (beat_q != last_q) begin
                    beat_q <= beat_q + 2'd1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (core_req_valid) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (mem_resp_valid) state_d = (beat_q == last_q) ? DONE : ISSUE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        core_req_ready  = 1'b0;
        core_resp_valid = 1'b0;
        core_resp_data  = '0;
        mem_req_valid   = 1'b0;
        mem_req_addr    = '0;
        mem_req_data    = '0;
        mem_req_fcn     = 1'b0;
        mem_req_typ     = '0;
        case (state_q)
            IDLE: core_req_ready = 1'b1;
            ISSUE: begin
                mem_req_valid = 1'b1;
                mem_req_fcn   = req_fcn_q;
                if (split_q) begin
                    mem_req_addr = req_addr_q + {30'h0, beat_q};
                    mem_req_data = {24'h0, beat_byte(req_data_q, beat_q)};
                    mem_req_typ  = MT_B;
                end else begin
                    mem_req_addr = req_addr_q;
                    mem_req_data = req_data_q;
                    mem_req_typ  = req_typ_q;
                end
            end
            DONE: begin
                core_resp_valid = 1'b1;
                if (req_fcn_q == M_XWR) begin
                    core_resp_data = '0;
                end else if (split_q && req_typ_q == MT_H) begin
                    core_resp_data = {16'h0, merge_q[15:0]};
                end else begin
                    core_resp_data = merge_q;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dmem_misalign_splitter.sv
// Scoreboard bench for dmem_misalign_splitter: expected beats and responses
// are queued at stimulus time and checked when the DUT produces them.
module tb_dmem_misalign_splitter;
    import dmem_misalign_splitter_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        stray;

    logic        core_req_valid, core_req_ready, core_req_fcn;
    logic [31:0] core_req_addr, core_req_data;
    logic [2:0]  core_req_typ;
    logic        core_resp_valid;
    logic [31:0] core_resp_data;
    logic        mem_req_valid, mem_req_fcn;
    logic [31:0] mem_req_addr, mem_req_data;
    logic [2:0]  mem_req_typ;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;

    logic        ns_core_req_valid, ns_core_req_ready, ns_core_req_fcn;
    logic [31:0] ns_core_req_addr, ns_core_req_data;
    logic [2:0]  ns_core_req_typ;
    logic        ns_core_resp_valid;
    logic [31:0] ns_core_resp_data;
    logic        ns_mem_req_valid, ns_mem_req_fcn;
    logic [31:0] ns_mem_req_addr, ns_mem_req_data;
    logic [2:0]  ns_mem_req_typ;
    logic        ns_mem_resp_valid;
    logic [31:0] ns_mem_resp_data;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        fcn;
        logic [2:0]  typ;
    } beat_t;

    typedef struct {
        logic [31:0] data;
        int          lat;
    } resp_t;

    beat_t       beat_q[$];
    resp_t       resp_q[$];
    beat_t       exp_b;
    resp_t       exp_r;
    int          cyc = 0;
    int          accept_cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  mem_b [16];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    dmem_misalign_splitter #(.SPLIT_EN(1'b1)) u_dut (
        .clock           (clock),
        .reset           (reset),
        .core_req_valid  (core_req_valid),
        .core_req_ready  (core_req_ready),
        .core_req_addr   (core_req_addr),
        .core_req_data   (core_req_data),
        .core_req_fcn    (core_req_fcn),
        .core_req_typ    (core_req_typ),
        .core_resp_valid (core_resp_valid),
        .core_resp_data  (core_resp_data),
        .mem_req_valid   (mem_req_valid),
        .mem_req_addr    (mem_req_addr),
        .mem_req_data    (mem_req_data),
        .mem_req_fcn     (mem_req_fcn),
        .mem_req_typ     (mem_req_typ),
        .mem_resp_valid  (mem_resp_valid),
        .mem_resp_data   (mem_resp_data)
    );

    dmem_misalign_splitter #(.SPLIT_EN(1'b0)) u_ns (
        .clock           (clock),
        .reset           (reset),
        .core_req_valid  (ns_core_req_valid),
        .core_req_ready  (ns_core_req_ready),
        .core_req_addr   (ns_core_req_addr),
        .core_req_data   (ns_core_req_data),
        .core_req_fcn    (ns_core_req_fcn),
        .core_req_typ    (ns_core_req_typ),
        .core_resp_valid (ns_core_resp_valid),
        .core_resp_data  (ns_core_resp_data),
        .mem_req_valid   (ns_mem_req_valid),
        .mem_req_addr    (ns_mem_req_addr),
        .mem_req_data    (ns_mem_req_data),
        .mem_req_fcn     (ns_mem_req_fcn),
        .mem_req_typ     (ns_mem_req_typ),
        .mem_resp_valid  (ns_mem_resp_valid),
        .mem_resp_data   (ns_mem_resp_data)
    );

    // 16-byte read-only memory, byte data LSB-aligned, one-cycle response.
    function automatic logic [31:0] mem_read(input logic [31:0] a, input logic [2:0] t);
        logic [3:0]  i;
        logic [31:0] w;
        i = a[3:0];
        w = {mem_b[i + 4'd3], mem_b[i + 4'd2], mem_b[i + 4'd1], mem_b[i]};
        case (t)
            MT_B:    return {24'h0, w[7:0]};
            MT_H:    return {16'h0, w[15:0]};
            default: return w;
        endcase
    endfunction

    always @(posedge clock) begin
        mem_resp_valid    <= mem_req_valid | stray;
        mem_resp_data     <= mem_read(mem_req_addr, mem_req_typ);
        ns_mem_resp_valid <= ns_mem_req_valid;
        ns_mem_resp_data  <= 32'hCAFEF00D;
    end

    always @(negedge clock) begin
        if (core_req_valid && core_req_ready) accept_cyc = cyc;
        if (mem_req_valid === 1'b1) begin
            n_cmp++;
            if (beat_q.size() == 0) begin
                n_err++;
                $display("FAIL beat_extra got addr=%h data=%h typ=%0d, none expected",
                         mem_req_addr, mem_req_data, mem_req_typ);
            end else begin
                exp_b = beat_q.pop_front();
                if ({mem_req_addr, mem_req_data, mem_req_fcn, mem_req_typ} !==
                    {exp_b.addr, exp_b.data, exp_b.fcn, exp_b.typ}) begin
                    n_err++;
                    $display("FAIL beat got addr=%h data=%h fcn=%b typ=%0d want addr=%h data=%h fcn=%b typ=%0d",
                             mem_req_addr, mem_req_data, mem_req_fcn, mem_req_typ,
                             exp_b.addr, exp_b.data, exp_b.fcn, exp_b.typ);
                end
            end
        end
        if (core_resp_valid === 1'b1) begin
            n_cmp++;
            if (resp_q.size() == 0) begin
                n_err++;
                $display("FAIL resp_extra got data=%h, none expected", core_resp_data);
            end else begin
                exp_r = resp_q.pop_front();
                if (core_resp_data !== exp_r.data || (cyc - accept_cyc) != exp_r.lat) begin
                    n_err++;
                    $display("FAIL resp got data=%h lat=%0d want data=%h lat=%0d",
                             core_resp_data, cyc - accept_cyc, exp_r.data, exp_r.lat);
                end
            end
        end
    end

    task automatic push_beat(input logic [31:0] a, input logic [31:0] d, input logic f, input logic [2:0] t);
        beat_t b;
        b.addr = a; b.data = d; b.fcn = f; b.typ = t;
        beat_q.push_back(b);
    endtask

    task automatic push_resp(input logic [31:0] d, input int lat);
        resp_t r;
        r.data = d; r.lat = lat;
        resp_q.push_back(r);
    endtask

    // Reference model of the beat plan and merged response.
    task automatic push_expect(input logic [31:0] a, input logic [31:0] d, input logic f, input logic [2:0] t);
        int          n;
        logic [31:0] r;
        n = 1;
        if (t == 3'd2 && a[0]) n = 2;
        if (t == 3'd3 && a[1:0] != 2'b00) n = 4;
        if (n == 1) begin
            push_beat(a, d, f, t);
            push_resp(f ? 32'h0 : mem_read(a, t), 3);
        end else begin
            r = 32'h0;
            for (int k = 0; k < n; k++) begin
                push_beat(a + k, (d >> (8 * k)) & 32'hFF, f, 3'd1);
                r = r | (mem_read(a + k, 3'd1) << (8 * k));
            end
            push_resp(f ? 32'h0 : r, 2 * n + 1);
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] d, input logic f, input logic [2:0] t);
        int i;
        core_req_addr = a; core_req_data = d; core_req_fcn = f; core_req_typ = t;
        core_req_valid = 1'b1;
        for (i = 0; i < 20; i++) begin
            @(negedge clock);
            if (core_req_ready === 1'b1) break;
        end
        if (i == 20) begin
            n_cmp++; n_err++;
            $display("FAIL accept_timeout got ready=%b want 1 within 20 cycles", core_req_ready);
        end
        @(posedge clock); #1;
        core_req_valid = 1'b0;
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 60; i++) begin
            @(negedge clock);
            if (beat_q.size() == 0 && resp_q.size() == 0) break;
        end
        if (i == 60) begin
            n_cmp++; n_err++;
            $display("FAIL drain_timeout got %0d beats %0d resps pending want 0",
                     beat_q.size(), resp_q.size());
            beat_q.delete(); resp_q.delete();
        end
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        n_cmp++;
        if ({core_req_ready, core_resp_valid, core_resp_data, mem_req_valid, mem_req_addr,
             mem_req_data, mem_req_fcn, mem_req_typ} !== {1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 3'h0}) begin
            n_err++;
            $display("FAIL reset_outputs got ready=%b rv=%b rd=%h mv=%b ma=%h md=%h mf=%b mt=%0d want ready=1 rest 0",
                     core_req_ready, core_resp_valid, core_resp_data, mem_req_valid, mem_req_addr,
                     mem_req_data, mem_req_fcn, mem_req_typ);
        end
        n_cmp++;
        if ({u_dut.beat_q, u_dut.merge_q} !== 34'h0) begin
            n_err++;
            $display("FAIL reset_regs got beat=%0d merge=%h want 0 0", u_dut.beat_q, u_dut.merge_q);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_aligned_read();
        push_beat(32'h8, 32'h0, 1'b0, 3'd3);
        push_resp(32'hDDCCBBAA, 3);
        send(32'h8, 32'h0, 1'b0, 3'd3);
        drain();
    endtask

    task automatic test_split_write();
        push_beat(32'h5, 32'h11, 1'b1, 3'd1);
        push_beat(32'h6, 32'h22, 1'b1, 3'd1);
        push_beat(32'h7, 32'h33, 1'b1, 3'd1);
        push_beat(32'h8, 32'h44, 1'b1, 3'd1);
        push_resp(32'h0, 9);
        send(32'h5, 32'h44332211, 1'b1, 3'd3);
        drain();
    endtask

    task automatic test_split_half();
        push_beat(32'h3, 32'h0, 1'b0, 3'd1);
        push_beat(32'h4, 32'h0, 1'b0, 3'd1);
        push_resp(32'h00005511, 5);
        send(32'h3, 32'h0, 1'b0, 3'd2);
        drain();
    endtask

    task automatic test_back_to_back();
        int t;
        int i;
        push_beat(32'h8, 32'h0, 1'b0, 3'd3);
        push_resp(32'hDDCCBBAA, 3);
        push_beat(32'hA, 32'h0, 1'b0, 3'd1);
        push_resp(32'h000000CC, 3);
        core_req_addr = 32'h8; core_req_data = 32'h0; core_req_fcn = 1'b0; core_req_typ = 3'd3;
        core_req_valid = 1'b1;
        for (i = 0; i < 20; i++) begin
            @(negedge clock);
            if (core_req_ready === 1'b1) break;
        end
        t = cyc;
        @(posedge clock); #1;
        core_req_addr = 32'hA; core_req_typ = 3'd1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clock);
            n_cmp++;
            if (core_req_ready !== 1'b0) begin
                n_err++;
                $display("FAIL b2b_ready_low cycle T+%0d got %b want 0", k, core_req_ready);
            end
        end
        @(negedge clock);
        n_cmp++;
        if (core_req_ready !== 1'b1 || cyc != t + 4) begin
            n_err++;
            $display("FAIL b2b_second_accept got ready=%b at T+%0d want 1 at T+4", core_req_ready, cyc - t);
        end
        @(posedge clock); #1;
        core_req_valid = 1'b0;
        drain();
    endtask

    task automatic test_reset_mid();
        push_beat(32'h5, 32'h0, 1'b0, 3'd1);
        push_beat(32'h6, 32'h0, 1'b0, 3'd1);
        send(32'h5, 32'h0, 1'b0, 3'd3);
        repeat (3) begin
            @(posedge clock); #1;
        end
        n_cmp++;
        if (beat_q.size() != 0 || u_dut.state_q != WAIT) begin
            n_err++;
            $display("FAIL mid_before_reset got %0d beats pending state=%0d want 0 and WAIT",
                     beat_q.size(), u_dut.state_q);
        end
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        n_cmp++;
        if ({core_req_ready, core_resp_valid, core_resp_data, mem_req_valid, mem_req_addr,
             mem_req_data, mem_req_fcn, mem_req_typ} !== {1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 3'h0}) begin
            n_err++;
            $display("FAIL mid_reset_outputs got ready=%b rv=%b mv=%b ma=%h want ready=1 rest 0",
                     core_req_ready, core_resp_valid, mem_req_valid, mem_req_addr);
        end
        repeat (6) @(negedge clock);
        @(posedge clock); #1;
        push_beat(32'h3, 32'h0, 1'b0, 3'd1);
        push_beat(32'h4, 32'h0, 1'b0, 3'd1);
        push_resp(32'h00005511, 5);
        send(32'h3, 32'h0, 1'b0, 3'd2);
        drain();
    endtask

    task automatic test_noop();
        push_beat(32'h2, 32'h12345678, 1'b0, 3'd0);
        push_resp(32'hE55511E2, 3);
        send(32'h2, 32'h12345678, 1'b0, 3'd0);
        drain();
    endtask

    task automatic test_stray_resp();
        push_beat(32'h3, 32'h0, 1'b0, 3'd1);
        push_beat(32'h4, 32'h0, 1'b0, 3'd1);
        push_resp(32'h00005511, 5);
        stray = 1'b1;
        send(32'h3, 32'h0, 1'b0, 3'd2);
        stray = 1'b0;
        drain();
    endtask

    task automatic test_random();
        logic [31:0] a, d;
        logic        f;
        logic [2:0]  t;
        for (int i = 0; i < 8; i++) begin
            a = 32'($urandom_range(0, 15));
            d = $urandom;
            f = 1'($urandom_range(0, 1));
            t = 3'($urandom_range(0, 3));
            push_expect(a, d, f, t);
            send(a, d, f, t);
            drain();
        end
    endtask

    task automatic test_nosplit();
        int          t_acc, t_beat, t_resp, nbeat;
        logic [31:0] b_addr, b_data, r_data;
        logic        b_fcn, f;
        logic [2:0]  b_typ;
        for (int j = 0; j < 2; j++) begin
            f = (j == 0);
            ns_core_req_addr = 32'h5; ns_core_req_data = 32'h44332211;
            ns_core_req_fcn = f; ns_core_req_typ = 3'd3; ns_core_req_valid = 1'b1;
            t_acc = -1; t_beat = -1; t_resp = -1; nbeat = 0;
            b_addr = '0; b_data = '0; b_fcn = 1'b0; b_typ = '0; r_data = 'x;
            for (int i = 0; i < 12; i++) begin
                @(negedge clock);
                if (ns_core_req_valid && ns_core_req_ready && t_acc < 0) t_acc = cyc;
                if (ns_mem_req_valid) begin
                    nbeat++; t_beat = cyc;
                    b_addr = ns_mem_req_addr; b_data = ns_mem_req_data;
                    b_fcn = ns_mem_req_fcn; b_typ = ns_mem_req_typ;
                end
                if (ns_core_resp_valid) begin
                    t_resp = cyc; r_data = ns_core_resp_data;
                end
                @(posedge clock); #1;
                if (t_acc >= 0) ns_core_req_valid = 1'b0;
            end
            n_cmp++;
            if (nbeat != 1 || {b_addr, b_data, b_fcn, b_typ} !== {32'h5, 32'h44332211, f, 3'd3} ||
                t_acc < 0 || t_beat != t_acc + 1) begin
                n_err++;
                $display("FAIL nosplit_beat got n=%0d addr=%h data=%h fcn=%b typ=%0d at T+%0d want n=1 addr=5 data=44332211 fcn=%b typ=3 at T+1",
                         nbeat, b_addr, b_data, b_fcn, b_typ, t_beat - t_acc, f);
            end
            n_cmp++;
            if (t_acc < 0 || t_resp != t_acc + 3 || r_data !== (f ? 32'h0 : 32'hCAFEF00D)) begin
                n_err++;
                $display("FAIL nosplit_resp got data=%h at T+%0d want data=%h at T+3",
                         r_data, t_resp - t_acc, f ? 32'h0 : 32'hCAFEF00D);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem_b[i] = 8'hE0 + 8'(i);
        mem_b[3] = 8'h11; mem_b[4] = 8'h55;
        mem_b[8] = 8'hAA; mem_b[9] = 8'hBB; mem_b[10] = 8'hCC; mem_b[11] = 8'hDD;
        reset = 1'b1; stray = 1'b0;
        core_req_valid = 1'b0; core_req_addr = '0; core_req_data = '0;
        core_req_fcn = 1'b0; core_req_typ = '0;
        ns_core_req_valid = 1'b0; ns_core_req_addr = '0; ns_core_req_data = '0;
        ns_core_req_fcn = 1'b0; ns_core_req_typ = '0;

        test_reset();
        test_aligned_read();
        test_split_write();
        test_split_half();
        test_back_to_back();
        test_reset_mid();
        test_noop();
        test_stray_resp();
        test_random();
        test_nosplit();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
